// File: rtl/mv_vector_scheduler.sv
// Matrix-vector sequencer for the 16-lane dot-product unit: walks rows x chunks, drives
// buffer reads and input_valid, and labels each returning result from an in-flight tag FIFO.
module mv_vector_scheduler #(
  parameter int ROW_W  = 10,
  parameter int COL_W  = 10,
  parameter int ADDR_W = 20,
  parameter int RD_LAT = 1,
  parameter int DEPTH  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ROW_W-1:0]  num_rows_i,
  input  logic [COL_W-1:0]  num_chunks_i,
  input  logic [ADDR_W-1:0] mat_base_i,
  output logic              mat_rd_en_o,
  output logic [ADDR_W-1:0] mat_rd_addr_o,
  output logic [COL_W-1:0]  vec_rd_addr_o,
  output logic              vu_input_valid_o,
  input  logic              vu_add_valid_i,
  output logic              res_valid_o,
  output logic [ROW_W-1:0]  res_row_o,
  output logic [COL_W-1:0]  res_chunk_o,
  output logic              res_last_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ROW_W-1:0] ROW_ONE = ROW_W'(1);
  localparam logic [COL_W-1:0] COL_ONE = COL_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] chunk;
  } tag_t;

  state_t            state_q;
  logic [ROW_W-1:0]  rows_q, row_q;
  logic [COL_W-1:0]  chunks_q, chunk_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  outst_q;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic              err_q;
  logic [RD_LAT:1]   vld_pipe_q;
  tag_t              fifo_q [DEPTH];

  logic issue, ret_ok, start_ok, last_chunk, last_row;
  tag_t head;

  // Issue is gated by the registered count, so a slot freed this cycle is reused next cycle.
  assign issue      = (state_q == S_ISSUE) && (outst_q < DEPTH_C);
  assign ret_ok     = vu_add_valid_i && (outst_q != '0);
  assign start_ok   = start_i && (state_q == S_IDLE);
  assign last_chunk = (chunk_q == chunks_q - COL_ONE);
  assign last_row   = (row_q == rows_q - ROW_ONE);
  assign head       = fifo_q[rd_ptr_q];

  assign mat_rd_en_o      = issue;
  assign mat_rd_addr_o    = addr_q;
  assign vec_rd_addr_o    = chunk_q;
  assign vu_input_valid_o = vld_pipe_q[RD_LAT];
  assign res_valid_o      = ret_ok;
  assign res_row_o        = ret_ok ? head.row : '0;
  assign res_chunk_o      = ret_ok ? head.chunk : '0;
  assign res_last_o       = ret_ok && (head.chunk == chunks_q - COL_ONE);
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = (state_q == S_DONE);
  assign err_o            = err_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      chunks_q   <= '0;
      row_q      <= '0;
      chunk_q    <= '0;
      addr_q     <= '0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
      vld_pipe_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          rows_q   <= num_rows_i;
          chunks_q <= num_chunks_i;
          addr_q   <= mat_base_i;
          row_q    <= '0;
          chunk_q  <= '0;
          state_q  <= (num_rows_i == '0 || num_chunks_i == '0) ? S_DONE : S_ISSUE;
        end
        S_ISSUE: if (issue) begin
          addr_q <= addr_q + ADDR_W'(1);
          if (last_chunk) begin
            chunk_q <= '0;
            if (last_row) state_q <= S_DRAIN;
            else          row_q   <= row_q + ROW_ONE;
          end else begin
            chunk_q <= chunk_q + COL_ONE;
          end
        end
        S_DRAIN: if (outst_q == '0 && vld_pipe_q == '0) state_q <= S_DONE;
        default: state_q <= S_IDLE;
      endcase

      case ({issue, ret_ok})
        2'b10:   outst_q <= outst_q + CNT_W'(1);
        2'b01:   outst_q <= outst_q - CNT_W'(1);
        default: outst_q <= outst_q;
      endcase
      if (issue)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (ret_ok) rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      // A stray result in the same cycle as an accepted start still flags an error.
      if (start_ok) err_q <= 1'b0;
      if (vu_add_valid_i && outst_q == '0) err_q <= 1'b1;

      vld_pipe_q[1] <= issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe_q[i] <= vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (issue) fifo_q[wr_ptr_q] <= '{row: row_q, chunk: chunk_q};
  end

endmodule

// File: tb/tb_mv_vector_scheduler.sv
// Randomized bench for mv_vector_scheduler: a queue-based job model predicts every cycle's
// read strobe, address, result tag, done, busy and err, with a fixed-latency unit model.
module tb_mv_vector_scheduler;
  localparam int ROW_W = 10, COL_W = 10, ADDR_W = 20, RD_LAT = 1, DEPTH = 8;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, vu_add_valid = 1'b0;
  logic [ROW_W-1:0]  num_rows = '0;
  logic [COL_W-1:0]  num_chunks = '0;
  logic [ADDR_W-1:0] mat_base = '0;
  logic              mat_rd_en, vu_input_valid, res_valid, res_last, busy, done, err;
  logic [ADDR_W-1:0] mat_rd_addr;
  logic [COL_W-1:0]  vec_rd_addr, res_chunk;
  logic [ROW_W-1:0]  res_row;

  mv_vector_scheduler #(.ROW_W(ROW_W), .COL_W(COL_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT),
                        .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_rows_i(num_rows),
    .num_chunks_i(num_chunks), .mat_base_i(mat_base), .mat_rd_en_o(mat_rd_en),
    .mat_rd_addr_o(mat_rd_addr), .vec_rd_addr_o(vec_rd_addr),
    .vu_input_valid_o(vu_input_valid), .vu_add_valid_i(vu_add_valid),
    .res_valid_o(res_valid), .res_row_o(res_row), .res_chunk_o(res_chunk),
    .res_last_o(res_last), .busy_o(busy), .done_o(done), .err_o(err));

  always #5 clk = ~clk;

  typedef struct {
    int row;
    int chunk;
    bit last;
    int addr;
  } op_t;

  op_t pend[$];
  op_t tags[$];
  int  ret_at[$];
  int  out_cnt = 0, cycle = 0, done_cyc = -1, lat = 1;
  bit  prev_en = 0, err_m = 0, busy_m = 0;
  int  checks = 0, failures = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  // One clock cycle: check outputs at negedge, advance the model, drive next inputs.
  task automatic cyc();
    bit  exp_en, exp_rv, add;
    op_t t;
    add = vu_add_valid;
    if (rst) begin
      pend.delete(); tags.delete();
      out_cnt = 0; prev_en = 0; err_m = 0; busy_m = 0; done_cyc = -1;
    end
    @(negedge clk);
    exp_en = (pend.size() > 0) && (out_cnt < DEPTH);
    chk("rd_en", mat_rd_en, exp_en);
    if (exp_en) begin
      chk("rd_addr", mat_rd_addr, pend[0].addr);
      chk("vec_addr", vec_rd_addr, pend[0].chunk);
    end
    chk("in_vld", vu_input_valid, prev_en);
    exp_rv = add && (out_cnt > 0);
    chk("res_vld", res_valid, exp_rv);
    if (exp_rv) begin
      chk("res_row", res_row, tags[0].row);
      chk("res_chunk", res_chunk, tags[0].chunk);
      chk("res_last", res_last, tags[0].last);
    end
    chk("done", done, cycle == done_cyc);
    chk("busy", busy, busy_m);
    chk("err", err, err_m);
    if (!rst) begin
      if (exp_rv) void'(tags.pop_front());
      if (exp_en) begin
        t = pend.pop_front();
        tags.push_back(t);
        ret_at.push_back(cycle + RD_LAT + lat);
      end
      out_cnt = out_cnt + int'(exp_en) - int'(exp_rv);
      if (start && !busy_m) begin
        err_m = 0;
        busy_m = 1;
        for (int r = 0; r < int'(num_rows); r++)
          for (int c = 0; c < int'(num_chunks); c++) begin
            t.row = r; t.chunk = c; t.last = (c == int'(num_chunks) - 1);
            t.addr = (int'(mat_base) + r * int'(num_chunks) + c) & ((1 << ADDR_W) - 1);
            pend.push_back(t);
          end
        if (pend.size() == 0) done_cyc = cycle + 1;
      end
      if (add && !exp_rv) err_m = 1;
      if (exp_rv && busy_m && tags.size() == 0 && pend.size() == 0) done_cyc = cycle + 2;
      if (cycle == done_cyc) busy_m = 0;
    end
    prev_en = exp_en && !rst;
    @(posedge clk);
    #1;
    cycle++;
    start = 0;
    vu_add_valid = 0;
    if (ret_at.size() > 0 && ret_at[0] == cycle) begin
      vu_add_valid = 1;
      void'(ret_at.pop_front());
    end
  endtask

  task automatic run_job(input int r, input int c, input int b, input int l, input bit glitch);
    int n;
    lat = l; num_rows = ROW_W'(r); num_chunks = COL_W'(c); mat_base = ADDR_W'(b);
    start = 1;
    cyc();
    n = 0;
    while ((busy_m || ret_at.size() > 0) && n < 3000) begin
      if (glitch && busy_m && $urandom_range(0, 3) == 0) begin
        start = 1;
        num_rows = ROW_W'($urandom);
        num_chunks = COL_W'($urandom);
        mat_base = ADDR_W'($urandom);
      end
      cyc();
      n++;
    end
    chk("job_timeout", n < 3000, 1);
    repeat (2) cyc();
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    rst = 0;
    repeat (2) cyc();

    run_job(2, 3, 'h100, 3, 0);
    run_job(1, 8, 'h2000, 10, 0);
    run_job(0, 5, 'h40, 2, 0);
    run_job(3, 0, 'h40, 2, 0);
    run_job(1, 20, 'h3ff00, DEPTH - 2, 0);
    run_job(3, 4, 'hffffe, 4, 1);

    // Abort a job with 5 ops in flight; their results must be discarded as errors.
    lat = 8; num_rows = 4; num_chunks = 4; mat_base = 'h500; start = 1;
    cyc();
    n = 0;
    while (out_cnt < 5 && n < 100) begin cyc(); n++; end
    chk("rst_inflight", out_cnt, 5);
    rst = 1;
    cyc();
    rst = 0;
    n = 0;
    while (ret_at.size() > 0 && n < 100) begin cyc(); n++; end
    cyc();
    chk("err_sticky", err, 1);
    run_job(2, 2, 'h77, 3, 0);
    chk("err_cleared", err, 0);

    for (int j = 0; j < 30; j++)
      run_job($urandom_range(0, 4), $urandom_range(0, 6), $urandom, $urandom_range(1, 12),
              $urandom_range(0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
